// File: rtl/prescaler_pkg.sv
// Shared types and constants for the two-stage prescaler timebase.
package prescaler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/prescaler_stage.sv
// One reloading down-counter stage: wraps when advanced at zero and registers a tick pulse.
module prescaler_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [W-1:0] reload_i,
  output logic         wrap_o,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Combinational wrap lets the next stage advance on the same edge.
  assign wrap_o = adv_i && (cnt_q == '0);
  assign tick_o = tick_q;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = reload_i;
    end else if (adv_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - W'(1);
      end else begin
        cnt_d  = reload_i;
        tick_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/prescaler_tick_gen.sv
// Two-stage programmable prescaler: tick enables at two divided rates, square wave,
// continuous/one-shot modes and divisor reload aligned to tick1 boundaries.
module prescaler_tick_gen
  import prescaler_pkg::*;
#(
  parameter int            W0       = 16,
  parameter int            W1       = 9,
  parameter logic [W0-1:0] DIV0_RST = {W0{1'b1}},
  parameter logic [W1-1:0] DIV1_RST = {W1{1'b1}}
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          en,
  input  logic          mode,
  input  logic          start,
  input  logic          div_load,
  input  logic [W0-1:0] div0_i,
  input  logic [W1-1:0] div1_i,
  output logic          tick0_o,
  output logic          tick1_o,
  output logic          sq_o,
  output logic          busy_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic          sq_q, sq_d;
  logic          done_q, done_d;
  logic          pending_q, pending_d;
  logic [W0-1:0] div0_act_q, div0_act_d, div0_sh_q, div0_sh_d;
  logic [W1-1:0] div1_act_q, div1_act_d, div1_sh_q, div1_sh_d;

  logic          run, adv0, start_run, wrap0, wrap1;
  logic [W0-1:0] reload0;
  logic [W1-1:0] reload1;

  assign run       = (state_q == RUN);
  assign adv0      = run && en;
  assign start_run = (state_q == IDLE) && en && ((mode == MODE_CONT) || start);

  // At a tick1 wrap the reload already uses the divisor that becomes active on this edge.
  always_comb begin
    reload0 = div0_act_q;
    reload1 = div1_act_q;
    if (div_load && (wrap1 || !run)) begin
      reload0 = div0_i;
      reload1 = div1_i;
    end else if (wrap1 && pending_q) begin
      reload0 = div0_sh_q;
      reload1 = div1_sh_q;
    end
  end

  prescaler_stage #(.W(W0)) u_stage0 (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .clr_i    (!en),
    .load_i   (start_run),
    .adv_i    (adv0),
    .reload_i (reload0),
    .wrap_o   (wrap0),
    .tick_o   (tick0_o)
  );

  prescaler_stage #(.W(W1)) u_stage1 (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .clr_i    (!en),
    .load_i   (start_run),
    .adv_i    (wrap0),
    .reload_i (reload1),
    .wrap_o   (wrap1),
    .tick_o   (tick1_o)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sq_d       = sq_q;
    done_d     = 1'b0;
    pending_d  = pending_q;
    div0_act_d = div0_act_q;
    div1_act_d = div1_act_q;
    div0_sh_d  = div0_sh_q;
    div1_sh_d  = div1_sh_q;

    case (state_q)
      IDLE: begin
        if (start_run) begin
          state_d = RUN;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (wrap1 && (mode_q == MODE_ONESHOT)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      sq_d = 1'b0;
    end else if (wrap1) begin
      sq_d = ~sq_q;
    end

    if (div_load) begin
      div0_sh_d = div0_i;
      div1_sh_d = div1_i;
      if (!adv0 || wrap1) begin
        div0_act_d = div0_i;
        div1_act_d = div1_i;
        pending_d  = 1'b0;
      end else begin
        pending_d  = 1'b1;
      end
    end else if (wrap1 && pending_q) begin
      div0_act_d = div0_sh_q;
      div1_act_d = div1_sh_q;
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      mode_q     <= MODE_CONT;
      sq_q       <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
      div0_act_q <= DIV0_RST;
      div1_act_q <= DIV1_RST;
      div0_sh_q  <= DIV0_RST;
      div1_sh_q  <= DIV1_RST;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sq_q       <= sq_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
      div0_act_q <= div0_act_d;
      div1_act_q <= div1_act_d;
      div0_sh_q  <= div0_sh_d;
      div1_sh_q  <= div1_sh_d;
    end
  end

  assign sq_o   = sq_q;
  assign done_o = done_q;
  assign busy_o = (state_q == RUN);

endmodule

// File: tb/tb_prescaler_tick_gen.sv
// Directed bench for prescaler_tick_gen using small widths (defaults D0=15, D1=7).
module tb_prescaler_tick_gen;

  localparam int W0 = 4;
  localparam int W1 = 3;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          en, mode, start, div_load;
  logic [W0-1:0] div0_i;
  logic [W1-1:0] div1_i;
  logic          tick0_o, tick1_o, sq_o, busy_o, done_o;

  int tests = 0;
  int fails = 0;

  prescaler_tick_gen #(.W0(W0), .W1(W1)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .en       (en),
    .mode     (mode),
    .start    (start),
    .div_load (div_load),
    .div0_i   (div0_i),
    .div1_i   (div1_i),
    .tick0_o  (tick0_o),
    .tick1_o  (tick1_o),
    .sq_o     (sq_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          en, mode, start, ld;
    logic [W0-1:0] d0;
    logic [W1-1:0] d1;
    logic          t0, t1, sq, busy, done;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic e, m, s, l, input logic [W0-1:0] a,
                              input logic [W1-1:0] b,
                              input logic t0, t1, q, bz, dn);
    vec_t v;
    v.en = e; v.mode = m; v.start = s; v.ld = l; v.d0 = a; v.d1 = b;
    v.t0 = t0; v.t1 = t1; v.sq = q; v.busy = bz; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick_cycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk_all_zero(input string name, input int cyc);
    chk({name, ".tick0"}, cyc, tick0_o, 0);
    chk({name, ".tick1"}, cyc, tick1_o, 0);
    chk({name, ".sq"},    cyc, sq_o,    0);
    chk({name, ".busy"},  cyc, busy_o,  0);
    chk({name, ".done"},  cyc, done_o,  0);
  endtask

  initial begin
    // One-shot D0=D1=1, then continuous D0=D1=1, then en low.
    vecs[0]  = mk(0,0,0,1, 1,1,  0,0,0,0,0);
    vecs[1]  = mk(1,1,0,0, 0,0,  0,0,0,0,0);
    vecs[2]  = mk(1,1,1,0, 0,0,  0,0,0,1,0);
    vecs[3]  = mk(1,1,1,0, 0,0,  0,0,0,1,0);
    vecs[4]  = mk(1,1,0,0, 0,0,  1,0,0,1,0);
    vecs[5]  = mk(1,1,0,0, 0,0,  0,0,0,1,0);
    vecs[6]  = mk(1,1,0,0, 0,0,  1,1,1,0,1);
    vecs[7]  = mk(1,1,0,0, 0,0,  0,0,1,0,0);
    vecs[8]  = mk(1,0,0,0, 0,0,  0,0,1,1,0);
    vecs[9]  = mk(1,0,0,0, 0,0,  0,0,1,1,0);
    vecs[10] = mk(1,0,0,0, 0,0,  1,0,1,1,0);
    vecs[11] = mk(1,0,0,0, 0,0,  0,0,1,1,0);
    vecs[12] = mk(1,0,0,0, 0,0,  1,1,0,1,0);
    vecs[13] = mk(0,0,0,0, 0,0,  0,0,0,0,0);

    PRESETn = 1'b1; en = 0; mode = 0; start = 0; div_load = 0; div0_i = '0; div1_i = '0;
    #2 PRESETn = 1'b0;
    #1 chk_all_zero("reset", 0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK) PRESETn = 1'b1;

    // Defaults: D0=15, D1=7 -> tick0 every 16, tick1 at 128.
    en = 1; mode = 0;
    tick_cycle();
    chk("dflt.busy", 0, busy_o, 1);
    for (int c = 1; c <= 130; c++) begin
      tick_cycle();
      chk("dflt.tick0", c, tick0_o, (c % 16 == 0) ? 1 : 0);
      chk("dflt.tick1", c, tick1_o, (c % 128 == 0) ? 1 : 0);
    end
    en = 0;
    tick_cycle();
    chk_all_zero("dflt.off", 131);

    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; start = vecs[i].start;
      div_load = vecs[i].ld; div0_i = vecs[i].d0; div1_i = vecs[i].d1;
      tick_cycle();
      chk("vec.tick0", i, tick0_o, vecs[i].t0);
      chk("vec.tick1", i, tick1_o, vecs[i].t1);
      chk("vec.sq",    i, sq_o,    vecs[i].sq);
      chk("vec.busy",  i, busy_o,  vecs[i].busy);
      chk("vec.done",  i, done_o,  vecs[i].done);
    end
    start = 0;

    // Load D0=3, D1=2 in IDLE, then run continuous.
    en = 0; mode = 0; div_load = 1; div0_i = 4'd3; div1_i = 3'd2;
    tick_cycle();
    div_load = 0; en = 1;
    tick_cycle();
    for (int c = 1; c <= 40; c++) begin
      if (c == 27) begin
        div_load = 1; div0_i = 4'd0; div1_i = 3'd0;
      end
      tick_cycle();
      div_load = 0;
      if (c < 36) begin
        chk("d32.tick0", c, tick0_o, (c % 4 == 0) ? 1 : 0);
        chk("d32.tick1", c, tick1_o, (c % 12 == 0) ? 1 : 0);
        chk("d32.sq",    c, sq_o,    (c / 12) % 2);
      end else begin
        chk("d00.tick0", c, tick0_o, 1);
        chk("d00.tick1", c, tick1_o, 1);
        chk("d00.sq",    c, sq_o,    (c - 35) % 2);
      end
      chk("run.busy", c, busy_o, 1);
    end

    // en dropped two cycles before tick1, then re-enable with unchanged divisors.
    en = 0; div_load = 1; div0_i = 4'd3; div1_i = 3'd2;
    tick_cycle();
    div_load = 0; en = 1;
    tick_cycle();
    for (int c = 1; c <= 13; c++) begin
      en = (c < 10) ? 1'b1 : 1'b0;
      tick_cycle();
      if (c < 10) begin
        chk("pre.tick0", c, tick0_o, (c % 4 == 0) ? 1 : 0);
        chk("pre.busy",  c, busy_o, 1);
      end else begin
        chk_all_zero("endrop", c);
      end
    end
    en = 1;
    tick_cycle();
    for (int c = 1; c <= 12; c++) begin
      tick_cycle();
      chk("re.tick0", c, tick0_o, (c % 4 == 0) ? 1 : 0);
      chk("re.tick1", c, tick1_o, (c == 12) ? 1 : 0);
      chk("re.sq",    c, sq_o,    (c == 12) ? 1 : 0);
    end

    // Asynchronous reset mid-run while tick0/tick1/sq/busy are high.
    #3 PRESETn = 1'b0;
    #1 chk_all_zero("arst", 0);
    @(posedge PCLK);
    @(negedge PCLK) PRESETn = 1'b1;
    tick_cycle();
    chk("arst.busy", 0, busy_o, 1);
    for (int c = 1; c <= 128; c++) begin
      tick_cycle();
      chk("arst.tick0", c, tick0_o, (c % 16 == 0) ? 1 : 0);
      chk("arst.tick1", c, tick1_o, (c % 128 == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
